// File: rtl/bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter for the 7-seg path.
// Optional BCD_CONVERTER_SIGNED_EN converts the magnitude of a signed value.
module bcd_converter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [WIDTH-1:0]    value,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                negative
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state;
  logic [BW-1:0]    scratch;
  logic [WIDTH-1:0] operand;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mag;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    scr_nx;
  logic [WIDTH-1:0] opd_nx;

`ifdef BCD_CONVERTER_SIGNED_EN
  logic sign;
  logic neg_q;
  assign sign = value[WIDTH-1];
  assign mag  = sign ? (~value + WIDTH'(1)) : value;
`else
  assign mag      = value;
  assign negative = 1'b0;
`endif

  // Add-3 correction precedes the shift so no digit exceeds 9 afterwards.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    {scr_nx, opd_nx} = {adj, operand} << 1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      scratch  <= '0;
      operand  <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
`ifdef BCD_CONVERTER_SIGNED_EN
      neg_q    <= 1'b0;
      negative <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            operand <= mag;
            scratch <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= S_SHIFT;
`ifdef BCD_CONVERTER_SIGNED_EN
            neg_q   <= sign;
`endif
          end
        end
        S_SHIFT: begin
          scratch <= scr_nx;
          operand <= opd_nx;
          cnt     <= cnt + CW'(1);
          // Result is published on the final shift edge with done.
          if (cnt == CW'(WIDTH - 1)) begin
            state    <= S_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            bcd      <= scr_nx;
`ifdef BCD_CONVERTER_SIGNED_EN
            negative <= neg_q;
`endif
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
